vga_vu_peak: RTL and testbench

Parametrised VU-meter renderer that sits between the VGA timing generator and the DAC pins, next to `vga_sig`. It draws `N_CH` rows of `N_BARS` vertical level bars with green/yellow/red zones and adds a per-bar peak-hold marker. The marker is held for a set number of frames and then decays. Levels are snapshotted once per frame during vertical sync, so the picture never tears, and all video outputs are registered.

---
 rtl/vga_vu_peak.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_vu_peak.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vu_peak.sv
// VU-meter overlay for a VGA pipeline: draws N_CH rows of N_BARS level bars
// with green/yellow/red zones and a per-bar peak-hold marker. Levels are
// snapshotted on the vsync falling edge and peaks are walked one bar per
// cycle during vertical blanking, so the visible picture never tears.
module vga_vu_peak #(
  parameter int N_CH        = 2,
  parameter int N_BARS      = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 2,
  parameter int MARKER_H    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*N_BARS*8-1:0] data,
  input  logic                     freeze,
  input  logic                     peak_en,
  input  logic                     hs_in,
  input  logic                     vs_in,
  input  logic                     active,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  output logic                     o_hs,
  output logic                     o_vs,
  output logic [2:0]               RED,
  output logic [2:0]               GREEN,
  output logic [1:0]               BLUE,
  output logic                     busy
);

  localparam int NB     = N_CH * N_BARS;
  localparam int ROW_H  = V_RES / N_CH;
  localparam int BW     = H_RES / N_BARS;
  localparam int HW     = 8 + $clog2(ROW_H);
  localparam int IW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            vs_prev_q;
  logic            vs_fall;
  logic            start_walk;

  // Committed per-bar registers, gathered for the pixel decoder.
  logic [7:0]      snap_w [NB];
  logic [7:0]      peak_w [NB];

  // Output pipeline registers.
  logic [2:0]      red_q, red_d;
  logic [2:0]      green_q, green_d;
  logic [1:0]      blue_q, blue_d;
  logic            hs_q, vs_q;

  // Bar pixel height: (L*ROW_H) >> 8, wide enough that the product never overflows.
  function automatic logic [9:0] bar_h(input logic [7:0] lvl);
    logic [HW-1:0] prod;
    prod = HW'(lvl) * HW'(ROW_H);
    return 10'(prod >> 8);
  endfunction

  assign vs_fall = vs_prev_q & ~vs_in;

  // FSM state, walk index and vsync edge register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vs_prev_q <= vs_in;
    end
  end

  // Next state: start a walk on an unfrozen vsync fall, step one bar per cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    start_walk = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_fall && !freeze) begin
          state_d    = UPDATE;
          idx_d      = '0;
          start_walk = 1'b1;
        end
      end
      UPDATE: begin
        if (idx_q == IW'(NB - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_bar
      logic [7:0]        snap_q;
      logic [7:0]        peak_q, peak_d;
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              upd;

      assign upd = (state_q == UPDATE) && (idx_q == IW'(gi));

      // Peak-hold step for this bar: capture, count down the hold, then decay to 0.
      always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (upd) begin
          if (snap_q >= peak_q) begin
            peak_d = snap_q;
            hold_d = HOLD_W'(HOLD_FRAMES);
          end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (peak_q > 8'(DECAY)) begin
            peak_d = peak_q - 8'(DECAY);
          end else begin
            peak_d = '0;
          end
        end
      end

      // Snapshot latch on walk start plus peak/hold state.
      always_ff @(posedge clk) begin
        if (!rst) begin
          snap_q <= '0;
          peak_q <= '0;
          hold_q <= '0;
        end else begin
          if (start_walk) begin
            snap_q <= data[NB*8-1-8*gi -: 8];
          end
          peak_q <= peak_d;
          hold_q <= hold_d;
        end
      end

      assign snap_w[gi] = snap_q;
      assign peak_w[gi] = peak_q;
    end
  endgenerate

  int            pix_row, pix_col, pix_xo, pix_rel, h_bar, h_pk;
  logic [IW-1:0] pix_k;
  logic          in_grid, in_x, bar_px, mark_px;

  // Pixel decoder: locate the bar under (x, y) and pick marker, zone colour or black.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    pix_row = int'(y) / ROW_H;
    pix_col = int'(x) / BW;
    pix_xo  = int'(x) - pix_col * BW;
    pix_rel = ROW_H - 1 - (int'(y) - pix_row * ROW_H);
    in_grid = (pix_row < N_CH) && (pix_col < N_BARS);
    pix_k   = IW'(pix_row * N_BARS + pix_col);
    h_bar   = 0;
    h_pk    = 0;
    if (in_grid) begin
      h_bar = int'(bar_h(snap_w[pix_k]));
      h_pk  = int'(bar_h(peak_w[pix_k]));
    end
    // One-pixel gutter on each side keeps neighbouring bars visually apart.
    in_x    = (pix_xo >= 1) && (pix_xo <= BW - 2);
    bar_px  = in_x && (pix_rel < h_bar);
    mark_px = peak_en && in_x && (h_pk >= 1) &&
              (pix_rel >= h_pk - MARKER_H) && (pix_rel < h_pk);
    if (active) begin
      if (mark_px) begin
        red_d   = 3'd7;
        green_d = 3'd7;
        blue_d  = 2'd3;
      end else if (bar_px) begin
        if (pix_rel >= (3 * ROW_H) / 4) begin
          red_d = 3'd7;
        end else if (pix_rel >= ROW_H / 2) begin
          red_d   = 3'd7;
          green_d = 3'd7;
        end else begin
          green_d = 3'd7;
        end
      end
    end
  end

  // Register colours and syncs together so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hs_q    <= hs_in;
      vs_q    <= vs_in;
    end
  end

  assign RED   = red_q;
  assign GREEN = green_q;
  assign BLUE  = blue_q;
  assign o_hs  = hs_q;
  assign o_vs  = vs_q;
  assign busy  = (state_q == UPDATE);

endmodule

// File: tb/tb_vga_vu_peak.sv
// Testbench for vga_vu_peak: a frame-level model of snapshot/peak behaviour
// checked every cycle, plus directed pixel probes with literal colours.
module tb_vga_vu_peak;

  localparam int N_CH   = 2;
  localparam int N_BARS = 8;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int HOLD   = 3;
  localparam int DECAY  = 2;
  localparam int MH     = 2;
  localparam int NB     = N_CH * N_BARS;
  localparam int ROW_H  = V_RES / N_CH;
  localparam int BW     = H_RES / N_BARS;

  localparam logic [7:0] C_BLK = 8'h00;
  localparam logic [7:0] C_RED = 8'hE0;
  localparam logic [7:0] C_YEL = 8'hFC;
  localparam logic [7:0] C_GRN = 8'h1C;
  localparam logic [7:0] C_WHT = 8'hFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB*8-1:0] data;
  logic            freeze, peak_en, hs_in, vs_in, active;
  logic [9:0]      x, y;
  logic            o_hs, o_vs, busy;
  logic [2:0]      RED, GREEN;
  logic [1:0]      BLUE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_vu_peak #(
    .N_CH(N_CH), .N_BARS(N_BARS), .H_RES(H_RES), .V_RES(V_RES),
    .HOLD_FRAMES(HOLD), .DECAY(DECAY), .MARKER_H(MH)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .freeze(freeze), .peak_en(peak_en),
    .hs_in(hs_in), .vs_in(vs_in), .active(active), .x(x), .y(y),
    .o_hs(o_hs), .o_vs(o_vs), .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int m_snap [NB];
  int m_peak [NB];
  int m_hold [NB];
  int m_vsp = 1;
  int m_cnt = 0;

  function automatic int m_h(input int lvl);
    return (lvl * ROW_H) / 256;
  endfunction

  function automatic logic [7:0] m_pix(input logic act, input int xx, input int yy, input logic pe);
    int row, col, idx, xin, up, hb, hpk;
    if (!act) return C_BLK;
    row = yy / ROW_H;
    col = xx / BW;
    if (row >= N_CH || col >= N_BARS) return C_BLK;
    idx = row * N_BARS + col;
    xin = xx % BW;
    up  = (row + 1) * ROW_H - 1 - yy;
    hb  = m_h(m_snap[idx]);
    hpk = m_h(m_peak[idx]);
    if (xin < 1 || xin > BW - 2) return C_BLK;
    if (pe && hpk >= 1 && up >= hpk - MH && up < hpk) return C_WHT;
    if (up < hb) begin
      if (up >= (3 * ROW_H) / 4) return C_RED;
      if (up >= ROW_H / 2) return C_YEL;
      return C_GRN;
    end
    return C_BLK;
  endfunction

  // Model advance and per-cycle compare of all registered outputs.
  initial begin : model
    logic            r, fz, pe, hsi, vsi, act;
    int              xi, yi, s;
    logic [NB*8-1:0] dcap;
    logic [7:0]      e_pix;
    logic            e_hs, e_vs;
    for (int k = 0; k < NB; k++) begin
      m_snap[k] = 0; m_peak[k] = 0; m_hold[k] = 0;
    end
    forever begin
      @(posedge clk);
      r = rst; fz = freeze; pe = peak_en; hsi = hs_in; vsi = vs_in; act = active;
      xi = int'(x); yi = int'(y); dcap = data;
      e_pix = r ? m_pix(act, xi, yi, pe) : C_BLK;
      if (!r) begin
        for (int k = 0; k < NB; k++) begin
          m_snap[k] = 0; m_peak[k] = 0; m_hold[k] = 0;
        end
        m_vsp = 1; m_cnt = 0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        e_hs = hsi; e_vs = vsi;
        if (m_cnt > 0) begin
          m_cnt--;
        end else if (m_vsp == 1 && !vsi && !fz) begin
          for (int k = 0; k < NB; k++) begin
            m_snap[k] = int'(dcap[NB*8-1-8*k -: 8]);
            s = m_snap[k];
            if (s >= m_peak[k]) begin
              m_peak[k] = s; m_hold[k] = HOLD;
            end else if (m_hold[k] > 0) begin
              m_hold[k]--;
            end else begin
              m_peak[k] = (m_peak[k] - DECAY < 0) ? 0 : m_peak[k] - DECAY;
            end
          end
          m_cnt = NB;
        end
        m_vsp = int'(vsi);
      end
      #1;
      chk("cycle", {RED, GREEN, BLUE, o_hs, o_vs, busy}, {e_pix, e_hs, e_vs, (m_cnt > 0)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_bar(input int k, input int lvl);
    data[NB*8-1-8*k -: 8] = 8'(lvl);
  endtask

  // Vsync pulse with blanking long enough for a full walk, then an optional column scan.
  task automatic vsync_frame(input int scan_x, output int nbusy);
    nbusy = 0;
    active = 1'b0;
    for (int i = 0; i < NB + 6; i++) begin
      vs_in = (i < 2) ? 1'b0 : 1'b1;
      @(posedge clk); #2;
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    if (scan_x >= 0) begin
      active = 1'b1;
      for (int yy = 0; yy < V_RES; yy++) begin
        x = 10'(scan_x); y = 10'(yy); hs_in = 1'($urandom);
        @(negedge clk);
      end
      active = 1'b0; hs_in = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic probe(input string nm, input int px, input int py, input logic pact,
                       input logic [7:0] exp);
    x = 10'(px); y = 10'(py); active = pact;
    @(posedge clk); #2;
    $display("probe %s x=%0d y=%0d rgb=%02h", nm, px, py, {RED, GREEN, BLUE});
    chk(nm, {RED, GREEN, BLUE}, exp);
    @(negedge clk);
    active = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n, tot;
    rst = 1'b0; data = '0; freeze = 1'b0; peak_en = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; active = 1'b0; x = '0; y = '0;

    chk("model_h255", m_h(255), 239);
    chk("model_h128", m_h(128), 120);
    chk("model_h0",   m_h(0),   0);
    chk("model_h100", m_h(100), 93);

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      hs_in = 1'($urandom); vs_in = 1'($urandom); active = 1'($urandom);
      x = 10'($urandom_range(639)); y = 10'($urandom_range(479));
      @(posedge clk); #2;
      chk("reset_outputs", {RED, GREEN, BLUE, o_hs, o_vs, busy}, {C_BLK, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
    end
    rst = 1'b1; vs_in = 1'b1; hs_in = 1'b1; active = 1'b0; data = '0;

    // Full-scale bar 0 and half-scale bar 8.
    set_bar(0, 255); set_bar(8, 128);
    vsync_frame(40, n);
    chk("busy_len_frame", n, NB);
    probe("b0_top_black",    40,   0, 1'b1, C_BLK);
    probe("b0_y1_red",       40,   1, 1'b1, C_RED);
    probe("b0_rel180_red",   40,  59, 1'b1, C_RED);
    probe("b0_rel179_yel",   40,  60, 1'b1, C_YEL);
    probe("b0_rel120_yel",   40, 119, 1'b1, C_YEL);
    probe("b0_rel119_grn",   40, 120, 1'b1, C_GRN);
    probe("b0_bottom_grn",   40, 239, 1'b1, C_GRN);
    probe("b0_x0_gutter",     0, 100, 1'b1, C_BLK);
    probe("b0_x79_gutter",   79, 100, 1'b1, C_BLK);
    probe("b0_x1_edge",       1, 239, 1'b1, C_GRN);
    probe("b0_x78_edge",     78, 239, 1'b1, C_GRN);
    probe("b0_inactive",     40, 100, 1'b0, C_BLK);
    probe("b8_rel119_lit",   40, 360, 1'b1, C_GRN);
    probe("b8_rel120_black", 40, 359, 1'b1, C_BLK);

    peak_en = 1'b1;
    probe("b0_mark_y1",   40,   1, 1'b1, C_WHT);
    probe("b0_mark_y2",   40,   2, 1'b1, C_WHT);
    probe("b0_below_mk",  40,   3, 1'b1, C_RED);
    probe("b8_mark",      40, 360, 1'b1, C_WHT);
    probe("b8_below_mk",  40, 362, 1'b1, C_GRN);

    // Peak hold then decay on bar 1.
    set_bar(1, 100);
    vsync_frame(120, n);
    probe("b1_f1_mark92", 120, 147, 1'b1, C_WHT);
    probe("b1_f1_mark91", 120, 148, 1'b1, C_WHT);
    probe("b1_f1_rel93",  120, 146, 1'b1, C_BLK);
    probe("b1_f1_rel90",  120, 149, 1'b1, C_GRN);
    set_bar(1, 0);
    for (int f = 2; f <= 4; f++) begin
      vsync_frame(-1, n);
      probe("b1_held", 120, 147, 1'b1, C_WHT);
    end
    vsync_frame(120, n);
    probe("b1_f5_mark",  120, 149, 1'b1, C_WHT);
    probe("b1_f5_old",   120, 148, 1'b1, C_BLK);
    vsync_frame(-1, n);
    probe("b1_f6_mark",  120, 150, 1'b1, C_WHT);
    probe("b1_f6_old",   120, 149, 1'b1, C_BLK);
    for (int f = 0; f < 52; f++) vsync_frame(-1, n);
    vsync_frame(120, n);
    probe("b1_sat_y2", 120, 2, 1'b1, C_BLK);
    probe("b1_sat_y3", 120, 3, 1'b1, C_BLK);

    // Level equal to peak keeps reloading the hold.
    set_bar(2, 50);
    for (int f = 0; f < 5; f++) vsync_frame(-1, n);
    set_bar(2, 0);
    for (int f = 0; f < 3; f++) vsync_frame(-1, n);
    probe("b2_eq_held45", 200, 194, 1'b1, C_WHT);
    probe("b2_eq_held44", 200, 195, 1'b1, C_WHT);
    vsync_frame(200, n);
    probe("b2_decay_old", 200, 194, 1'b1, C_BLK);
    probe("b2_decay_new", 200, 196, 1'b1, C_WHT);

    // Freeze across five vsyncs.
    freeze = 1'b1;
    set_bar(3, 200);
    tot = 0;
    for (int f = 0; f < 5; f++) begin
      vsync_frame(-1, n);
      tot += n;
    end
    chk("freeze_busy", tot, 0);
    probe("frz_snap_held", 280, 100, 1'b1, C_BLK);
    probe("frz_peak_held", 200, 196, 1'b1, C_WHT);
    freeze = 1'b0;
    vsync_frame(280, n);
    probe("b3_mark186", 280,  53, 1'b1, C_WHT);
    probe("b3_mark185", 280,  54, 1'b1, C_WHT);
    probe("b3_rel187",  280,  52, 1'b1, C_BLK);
    probe("b3_yel",     280,  60, 1'b1, C_YEL);
    probe("b3_grn",     280, 239, 1'b1, C_GRN);

    // Second vsync fall during the walk is ignored.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      vs_in = (i == 0 || i == 2) ? 1'b0 : 1'b1;
      @(posedge clk); #2;
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    chk("collide_busy_len", n, NB);

    // Reset in the middle of a walk.
    vs_in = 1'b0;
    @(negedge clk);
    vs_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    probe("rst_mid_b3", 280,  53, 1'b1, C_BLK);
    probe("rst_mid_b2", 200, 196, 1'b1, C_BLK);
    vsync_frame(280, n);
    chk("rst_mid_clean_walk", n, NB);
    probe("post_rst_mark", 280, 53, 1'b1, C_WHT);
    probe("post_rst_yel",  280, 60, 1'b1, C_YEL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
